// File: rtl/rr_arbiter_pkg.sv
// Shared constants and helpers for the rr_arbiter block.
// Arbitration modes plus a width helper that never returns zero bits.
package arb_pkg;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    function automatic int clog2_safe(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_if
    import arb_pkg::*;
#(
    parameter int N = 4
);
    localparam int ID_W = clog2_safe(N);

    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            valid;

    modport master (output req, input gnt, input gnt_id, input valid);
    modport slave  (input req, output gnt, output gnt_id, output valid);

endinterface

// File: rtl/rr_arbiter_prio_pick.sv
// Combinational rotating priority picker: first set, non-excluded req bit
// at or after base, wrapping modulo N.
module arb_prio_pick
    import arb_pkg::*;
#(
    parameter  int N    = 4,
    localparam int ID_W = clog2_safe(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] base,
    input  logic [N-1:0]    excl,
    output logic [N-1:0]    win_oh,
    output logic [ID_W-1:0] win_id,
    output logic            any
);

    logic [N-1:0]   masked;
    logic [2*N-1:0] dbl;
    int             offset;
    int             sum;

    // Doubling the vector lets a plain shift stand in for the wrap-around.
    always_comb begin
        masked = req & ~excl;
        dbl    = {masked, masked} >> base;
        any    = |masked;
        offset = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (dbl[i]) offset = i;
        end
        sum = offset + int'(base);
        if (sum >= N) sum = sum - N;
        win_id = ID_W'(sum);
        win_oh = '0;
        if (any) win_oh[win_id] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with registered one-hot grant, round-robin or fixed priority.
// Define ARB_LOCK_EN to let a grantee hold the grant for up to MAX_HOLD cycles.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MODE     = ARB_MODE_RR,
    parameter  int MAX_HOLD = 4,
    localparam int ID_W     = clog2_safe(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter_if.slave  bus
);

    if (N < 2 || N > 32 || MAX_HOLD < 1) begin : g_bad_cfg
        $error("rr_arbiter: unsupported parameter set");
    end

    logic [N-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            valid_q, valid_d;

    logic [ID_W-1:0] base;
    logic [N-1:0]    excl;
    logic [N-1:0]    win_oh;
    logic [ID_W-1:0] win_id;
    logic            pick_any;
    logic [ID_W-1:0] ptr_adv;

    assign base    = (MODE == ARB_MODE_FIXED) ? '0 : ptr_q;
    assign ptr_adv = (MODE == ARB_MODE_FIXED) ? '0 :
                     (win_id == ID_W'(N - 1)) ? '0 : win_id + 1'b1;

    arb_prio_pick #(.N(N)) u_pick (
        .req    (bus.req),
        .base   (base),
        .excl   (excl),
        .win_oh (win_oh),
        .win_id (win_id),
        .any    (pick_any)
    );

`ifdef ARB_LOCK_EN
    localparam int HC_W = clog2_safe(MAX_HOLD + 1);

    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
    logic            holding;
    logic            at_max;
    logic            others;

    assign holding = valid_q && |(bus.req & gnt_q);
    assign at_max  = (hold_cnt_q == HC_W'(MAX_HOLD));
    assign others  = |(bus.req & ~gnt_q);
    assign excl    = (holding && at_max) ? gnt_q : '0;

    // A holder keeps the grant unless its hold budget is spent and someone else waits.
    always_comb begin
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        valid_d    = valid_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        if (holding && !(at_max && others)) begin
            hold_cnt_d = at_max ? HC_W'(1) : hold_cnt_q + 1'b1;
        end else if (pick_any) begin
            gnt_d      = win_oh;
            gnt_id_d   = win_id;
            valid_d    = 1'b1;
            hold_cnt_d = HC_W'(1);
            if (win_oh != gnt_q) ptr_d = ptr_adv;
        end else begin
            gnt_d      = '0;
            valid_d    = 1'b0;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_cnt_q <= '0;
        else        hold_cnt_q <= hold_cnt_d;
    end
`else
    assign excl = '0;

    always_comb begin
        gnt_d    = '0;
        gnt_id_d = gnt_id_q;
        valid_d  = 1'b0;
        ptr_d    = ptr_q;
        if (pick_any) begin
            gnt_d    = win_oh;
            gnt_id_d = win_id;
            valid_d  = 1'b1;
            ptr_d    = ptr_adv;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q    <= '0;
            gnt_id_q <= '0;
            valid_q  <= 1'b0;
            ptr_q    <= '0;
        end else begin
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            valid_q  <= valid_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.valid  = valid_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: three instances (N=4 RR, N=4 fixed, N=3 RR) checked
// against directed expectations and a scan-based reference model.
module tb_rr_arbiter;

    localparam int MH   = 3;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] req_drv   [NDUT];
    logic [31:0] obs_gnt   [NDUT];
    logic [4:0]  obs_id    [NDUT];
    logic        obs_valid [NDUT];

    int m_ptr   [NDUT];
    int m_id    [NDUT];
    int m_hold  [NDUT];
    bit m_valid [NDUT];
    int m_n     [NDUT] = '{4, 4, 3};
    int m_mode  [NDUT] = '{0, 1, 0};

    rr_arbiter_if #(.N(4)) bus0 ();
    rr_arbiter_if #(.N(4)) bus1 ();
    rr_arbiter_if #(.N(3)) bus2 ();

    rr_arbiter #(.N(4), .MODE(0), .MAX_HOLD(MH)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    rr_arbiter #(.N(4), .MODE(1), .MAX_HOLD(MH)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    rr_arbiter #(.N(3), .MODE(0), .MAX_HOLD(MH)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    assign bus0.req = req_drv[0][3:0];
    assign bus1.req = req_drv[1][3:0];
    assign bus2.req = req_drv[2][2:0];

    assign obs_gnt[0]   = 32'(bus0.gnt);
    assign obs_gnt[1]   = 32'(bus1.gnt);
    assign obs_gnt[2]   = 32'(bus2.gnt);
    assign obs_id[0]    = 5'(bus0.gnt_id);
    assign obs_id[1]    = 5'(bus1.gnt_id);
    assign obs_id[2]    = 5'(bus2.gnt_id);
    assign obs_valid[0] = bus0.valid;
    assign obs_valid[1] = bus1.valid;
    assign obs_valid[2] = bus2.valid;

    always #5 clk = ~clk;

    function automatic int scan(input int n, input int base, input logic [31:0] r);
        for (int k = 0; k < n; k++) begin
            if (r[(base + k) % n]) return (base + k) % n;
        end
        return -1;
    endfunction

    function automatic void model_grant(input int d, input int w);
        m_valid[d] = 1'b1;
        m_id[d] = w;
        if (m_mode[d] == 0) m_ptr[d] = (w + 1) % m_n[d];
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < NDUT; d++) begin
            m_ptr[d] = 0;
            m_id[d] = 0;
            m_hold[d] = 0;
            m_valid[d] = 1'b0;
        end
    endfunction

    function automatic void model_step(input int d, input logic [31:0] r);
        int base;
        int w;
        logic [31:0] rest;
        base = (m_mode[d] == 1) ? 0 : m_ptr[d];
        rest = r;
`ifdef ARB_LOCK_EN
        if (m_valid[d] && r[m_id[d]]) begin
            rest[m_id[d]] = 1'b0;
            if (m_hold[d] >= MH && rest != 0) begin
                model_grant(d, scan(m_n[d], base, rest));
                m_hold[d] = 1;
            end else begin
                m_hold[d] = (m_hold[d] >= MH) ? 1 : m_hold[d] + 1;
            end
            return;
        end
        w = scan(m_n[d], base, rest);
        if (w >= 0) begin
            model_grant(d, w);
            m_hold[d] = 1;
        end else begin
            m_valid[d] = 1'b0;
            m_hold[d] = 0;
        end
`else
        w = scan(m_n[d], base, rest);
        if (w >= 0) model_grant(d, w);
        else m_valid[d] = 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_gnt(input int d);
        return m_valid[d] ? (32'd1 << m_id[d]) : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) model_step(d, req_drv[d]);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_drv[0] = 32'hF;
        req_drv[1] = 32'hF;
        req_drv[2] = 32'h7;
        model_reset();
        #3;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (obs_gnt[d] !== 32'd0 || obs_valid[d] !== 1'b0 || obs_id[d] !== 5'd0) begin
                failures++;
                $display("[TB] FAIL reset_hold dut%0d: gnt=%b valid=%b id=%0d, want 0/0/0",
                         d, obs_gnt[d], obs_valid[d], obs_id[d]);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (obs_gnt[0] !== 32'h1 || obs_id[0] !== 5'd0 || obs_valid[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_first_grant: gnt=%b id=%0d valid=%b, want 0001/0/1",
                     obs_gnt[0], obs_id[0], obs_valid[0]);
        end
        checks++;
        if (obs_gnt[2] !== 32'h1) begin
            failures++;
            $display("[TB] FAIL reset_first_grant_n3: gnt=%b, want 001", obs_gnt[2]);
        end
        step();
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (obs_gnt[d] !== 32'd0 || obs_valid[d] !== 1'b0 || obs_id[d] !== 5'd0) begin
                failures++;
                $display("[TB] FAIL reset_async dut%0d: gnt=%b valid=%b id=%0d, want 0/0/0",
                         d, obs_gnt[d], obs_valid[d], obs_id[d]);
            end
        end
        model_reset();
        req_drv[0] = 32'h0;
        req_drv[1] = 32'h0;
        req_drv[2] = 32'h0;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_rotation();
        logic [31:0] eg [5] = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
        int ei [5] = '{0, 1, 2, 3, 0};
        req_drv[0] = 32'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (obs_gnt[0] !== eg[i] || obs_id[0] !== 5'(ei[i])) begin
                failures++;
                $display("[TB] FAIL rotation[%0d]: gnt=%b id=%0d, want %b/%0d",
                         i, obs_gnt[0], obs_id[0], eg[i], ei[i]);
            end
        end
    endtask

    task automatic test_sparse();
        logic [31:0] eg [3] = '{32'h2, 32'h8, 32'h2};
        req_drv[0] = 32'hA;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_gnt[0] !== eg[i]) begin
                failures++;
                $display("[TB] FAIL sparse[%0d]: gnt=%b, want %b", i, obs_gnt[0], eg[i]);
            end
        end
        req_drv[0] = 32'h0;
        step();
        checks++;
        if (obs_gnt[0] !== 32'h0 || obs_valid[0] !== 1'b0 || obs_id[0] !== 5'd1) begin
            failures++;
            $display("[TB] FAIL idle_hold_id: gnt=%b valid=%b id=%0d, want 0/0/1",
                     obs_gnt[0], obs_valid[0], obs_id[0]);
        end
        req_drv[0] = 32'hC;
        step();
        checks++;
        if (obs_gnt[0] !== 32'h4 || obs_id[0] !== 5'd2) begin
            failures++;
            $display("[TB] FAIL sparse_resume: gnt=%b id=%0d, want 0100/2", obs_gnt[0], obs_id[0]);
        end
        req_drv[0] = 32'h0;
    endtask

    task automatic test_legacy();
        logic [31:0] rq [5] = '{32'hE, 32'hE, 32'hE, 32'h8, 32'h1};
        logic [31:0] eg [5] = '{32'h2, 32'h2, 32'h2, 32'h8, 32'h1};
        for (int i = 0; i < 5; i++) begin
            req_drv[1] = rq[i];
            step();
            checks++;
            if (obs_gnt[1] !== eg[i]) begin
                failures++;
                $display("[TB] FAIL legacy[%0d]: gnt=%b, want %b", i, obs_gnt[1], eg[i]);
            end
        end
        req_drv[1] = 32'h0;
    endtask

    task automatic test_non_pow2();
        logic [31:0] eg [4] = '{32'h1, 32'h2, 32'h4, 32'h1};
        req_drv[2] = 32'h7;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs_gnt[2] !== eg[i]) begin
                failures++;
                $display("[TB] FAIL non_pow2[%0d]: gnt=%b, want %b", i, obs_gnt[2], eg[i]);
            end
        end
        req_drv[2] = 32'h0;
    endtask

    task automatic test_lock();
        logic [31:0] eg [7] = '{32'h1, 32'h1, 32'h1, 32'h2, 32'h2, 32'h2, 32'h1};
        logic [31:0] rq [4] = '{32'h3, 32'h3, 32'h3, 32'h1};
        logic [31:0] eh [4] = '{32'h2, 32'h2, 32'h2, 32'h1};
        req_drv[0] = 32'h3;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (obs_gnt[0] !== eg[i]) begin
                failures++;
                $display("[TB] FAIL lock_share[%0d]: gnt=%b, want %b", i, obs_gnt[0], eg[i]);
            end
        end
        req_drv[0] = 32'h1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (obs_gnt[0] !== 32'h1 || obs_valid[0] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL lock_alone[%0d]: gnt=%b valid=%b, want 0001/1",
                         i, obs_gnt[0], obs_valid[0]);
            end
        end
        req_drv[0] = 32'h0;
        step();
        for (int i = 0; i < 4; i++) begin
            req_drv[0] = rq[i];
            step();
            checks++;
            if (obs_gnt[0] !== eh[i]) begin
                failures++;
                $display("[TB] FAIL lock_drop[%0d]: gnt=%b, want %b", i, obs_gnt[0], eh[i]);
            end
        end
        req_drv[0] = 32'h0;
    endtask

    task automatic test_random();
        logic [31:0] mask;
        logic [31:0] exp_gnt;
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < NDUT; d++) begin
                mask = (32'd1 << m_n[d]) - 32'd1;
                if ($urandom_range(0, 3) == 0) req_drv[d] = $urandom & mask;
            end
            step();
            for (int d = 0; d < NDUT; d++) begin
                exp_gnt = model_gnt(d);
                checks++;
                if (obs_gnt[d] !== exp_gnt || obs_valid[d] !== m_valid[d] ||
                    obs_id[d] !== 5'(m_id[d])) begin
                    failures++;
                    $display("[TB] FAIL random c%0d dut%0d: gnt=%b valid=%b id=%0d, want %b/%b/%0d",
                             c, d, obs_gnt[d], obs_valid[d], obs_id[d], exp_gnt, m_valid[d], m_id[d]);
                end
                checks++;
                if ((obs_gnt[d] & ~req_drv[d]) !== 32'd0) begin
                    failures++;
                    $display("[TB] FAIL random_gnt_without_req c%0d dut%0d: gnt=%b req=%b",
                             c, d, obs_gnt[d], req_drv[d]);
                end
            end
        end
        for (int d = 0; d < NDUT; d++) req_drv[d] = 32'h0;
    endtask

    initial begin
        test_reset();
`ifdef ARB_LOCK_EN
        test_lock();
`else
        test_rotation();
        test_sparse();
        test_legacy();
        test_non_pow2();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
